// File: rtl/x1_reset_ce_gen_if.sv
// Control/status bundle between the X1 reset/clock-enable generator and its environment.
// The slave side is the generator; the master side drives the lock and soft-reset inputs.
interface x1_reset_ce_gen_if;
  logic       pll_locked;
  logic       soft_rst;
  logic       sys_reset_n;
  logic       ce_cpu;
  logic       ce_psg;
  logic       running;
  logic [1:0] state;

  modport master (
    output pll_locked, soft_rst,
    input  sys_reset_n, ce_cpu, ce_psg, running, state
  );

  modport slave (
    input  pll_locked, soft_rst,
    output sys_reset_n, ce_cpu, ce_psg, running, state
  );
endinterface

// File: rtl/x1_reset_ce_gen.sv
// X1 core reset sequencer: synchronises/debounces PLL lock, holds the core in reset,
// then releases it and produces phase-accumulator clock enables for the Z80 and PSG.
module x1_reset_ce_gen #(
  parameter int CLK_HZ      = 32000000,
  parameter int CPU_HZ      = 4000000,
  parameter int PSG_HZ      = 2000000,
  parameter int LOCK_FILTER = 1024,
  parameter int RST_HOLD    = 65536
) (
  input  logic             clk,
  input  logic             rst_n,
  x1_reset_ce_gen_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'b00,
    HOLD      = 2'b01,
    RUN       = 2'b10
  } state_t;

  localparam int FW = $clog2(LOCK_FILTER);
  localparam int HW = $clog2(RST_HOLD);
  localparam logic [FW-1:0] FMAX  = FW'(LOCK_FILTER - 1);
  localparam logic [HW-1:0] HMAX  = HW'(RST_HOLD - 1);
  localparam logic [31:0]   CLK_K = 32'(CLK_HZ);
  localparam logic [31:0]   CPU_K = 32'(CPU_HZ);
  localparam logic [31:0]   PSG_K = 32'(PSG_HZ);

  // One accumulator step: MSB is the enable, low 32 bits the wrapped phase.
  // CLK_HZ < 2^31 and INC <= CLK_HZ/2 keep acc+inc inside 32 bits.
  function automatic logic [32:0] acc_step(input logic [31:0] acc, input logic [31:0] inc);
    logic [31:0] sum;
    sum = acc + inc;
    if (sum >= CLK_K) acc_step = {1'b1, sum - CLK_K};
    else              acc_step = {1'b0, sum};
  endfunction

  state_t      r_state;
  logic        r_sync1;
  logic        r_lock_s;
  logic [FW-1:0] r_fcnt;
  logic [HW-1:0] r_hcnt;
  logic [31:0] r_acc_cpu;
  logic [31:0] r_acc_psg;
  logic        r_ce_cpu;
  logic        r_ce_psg;
  logic        r_sys_reset_n;
  logic        r_running;

  logic [32:0] w_cpu_nxt;
  logic [32:0] w_psg_nxt;

  assign w_cpu_nxt = acc_step(r_acc_cpu, CPU_K);
  assign w_psg_nxt = acc_step(r_acc_psg, PSG_K);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= WAIT_LOCK;
      r_sync1       <= 1'b0;
      r_lock_s      <= 1'b0;
      r_fcnt        <= '0;
      r_hcnt        <= '0;
      r_acc_cpu     <= '0;
      r_acc_psg     <= '0;
      r_ce_cpu      <= 1'b0;
      r_ce_psg      <= 1'b0;
      r_sys_reset_n <= 1'b0;
      r_running     <= 1'b0;
    end else begin
      r_sync1  <= bus.pll_locked;
      r_lock_s <= r_sync1;
      // Enables default to frozen/phase-cleared; only a RUN edge that stays in RUN advances them.
      r_acc_cpu <= '0;
      r_acc_psg <= '0;
      r_ce_cpu  <= 1'b0;
      r_ce_psg  <= 1'b0;
      if (!r_lock_s) begin
        r_state       <= WAIT_LOCK;
        r_fcnt        <= '0;
        r_sys_reset_n <= 1'b0;
        r_running     <= 1'b0;
      end else if (bus.soft_rst && (r_state != WAIT_LOCK)) begin
        r_state       <= HOLD;
        r_hcnt        <= '0;
        r_sys_reset_n <= 1'b0;
        r_running     <= 1'b0;
      end else begin
        case (r_state)
          WAIT_LOCK: begin
            if (r_fcnt == FMAX) begin
              r_state <= HOLD;
              r_hcnt  <= '0;
            end else begin
              r_fcnt <= r_fcnt + FW'(1);
            end
          end
          HOLD: begin
            if (r_hcnt == HMAX) begin
              r_state       <= RUN;
              r_sys_reset_n <= 1'b1;
              r_running     <= 1'b1;
            end else begin
              r_hcnt <= r_hcnt + HW'(1);
            end
          end
          RUN: begin
            r_acc_cpu <= w_cpu_nxt[31:0];
            r_ce_cpu  <= w_cpu_nxt[32];
            r_acc_psg <= w_psg_nxt[31:0];
            r_ce_psg  <= w_psg_nxt[32];
          end
          default: begin
            r_state       <= WAIT_LOCK;
            r_fcnt        <= '0;
            r_sys_reset_n <= 1'b0;
            r_running     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sys_reset_n = r_sys_reset_n;
  assign bus.ce_cpu      = r_ce_cpu;
  assign bus.ce_psg      = r_ce_psg;
  assign bus.running     = r_running;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_x1_reset_ce_gen.sv
// Scoreboard bench for x1_reset_ce_gen: stimulus queues hand-computed output transitions,
// a monitor detects every output change and checks it against the queued expectation.
module tb_x1_reset_ce_gen;

  logic clk = 1'b0;
  logic rst_n;

  x1_reset_ce_gen_if bus();

  x1_reset_ce_gen #(
    .LOCK_FILTER(16),
    .RST_HOLD   (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] val;
  } ev_t;

  typedef struct {
    int cyc;
    int cpu;
    int psg;
  } cnt_t;

  localparam int R = 3;

  ev_t   q_ev [5][$];
  cnt_t  q_cnt[$];
  int    q_snap[$];
  string names[5] = '{"sys_reset_n", "running", "state", "ce_cpu", "ce_psg"};

  int n_tests = 0;
  int n_fail  = 0;
  int c_cpu   = 0;
  int c_psg   = 0;
  bit done    = 1'b0;

  logic [1:0] cur[5];
  logic [1:0] prv[5];

  task automatic expect_ev(input int id, input int c, input logic [1:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    q_ev[id].push_back(e);
  endtask

  task automatic expect_rst(input int c, input logic v);
    expect_ev(0, c, {1'b0, v});
    expect_ev(1, c, {1'b0, v});
  endtask

  // RUN begins after edge `base`; RUN cycle n ends at edge base+n. CPU every 8, PSG every 16.
  task automatic expect_ce(input int base, input int last);
    for (int n = 1; base + n <= last; n++) begin
      if (n % 8 == 0) begin
        expect_ev(3, base + n, 2'd1);
        expect_ev(3, base + n + 1, 2'd0);
      end
      if (n % 16 == 0) begin
        expect_ev(4, base + n, 2'd1);
        expect_ev(4, base + n + 1, 2'd0);
      end
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        for (int i = 0; i < 5; i++) begin
          n_tests++;
          if (q_ev[i].size() != 0) begin
            n_fail++;
            $display("FAIL %s leftover: %0d expected transitions never seen, required 0",
                     names[i], q_ev[i].size());
          end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
      cur[0] = {1'b0, bus.sys_reset_n};
      cur[1] = {1'b0, bus.running};
      cur[2] = bus.state;
      cur[3] = {1'b0, bus.ce_cpu};
      cur[4] = {1'b0, bus.ce_psg};
      if (q_snap.size() > 0 && q_snap[0] == cyc) begin
        void'(q_snap.pop_front());
        n_tests++;
        if ({cur[0], cur[1], cur[2], cur[3], cur[4]} !== 10'd0) begin
          n_fail++;
          $display("FAIL reset_values at cyc %0d: got rst_n_out=%0d run=%0d st=%0d cpu=%0d psg=%0d, required all 0",
                   cyc, cur[0], cur[1], cur[2], cur[3], cur[4]);
        end
      end
      if (cyc > R) begin
        for (int i = 0; i < 5; i++) begin
          if (cur[i] !== prv[i]) begin
            if (i == 3 && cur[i] == 2'd1) c_cpu++;
            if (i == 4 && cur[i] == 2'd1) c_psg++;
            n_tests++;
            if (q_ev[i].size() == 0) begin
              n_fail++;
              $display("FAIL %s unexpected change at cyc %0d to %0d, required no change",
                       names[i], cyc, cur[i]);
            end else begin
              ev_t e;
              e = q_ev[i].pop_front();
              if (e.cyc != cyc || e.val !== cur[i]) begin
                n_fail++;
                $display("FAIL %s: got cyc %0d val %0d, required cyc %0d val %0d",
                         names[i], cyc, cur[i], e.cyc, e.val);
              end
            end
          end
        end
      end
      if (q_cnt.size() > 0 && q_cnt[0].cyc == cyc) begin
        cnt_t k;
        k = q_cnt.pop_front();
        n_tests++;
        if (c_cpu != k.cpu || c_psg != k.psg) begin
          n_fail++;
          $display("FAIL pulse_count at cyc %0d: got cpu %0d psg %0d, required cpu %0d psg %0d",
                   cyc, c_cpu, c_psg, k.cpu, k.psg);
        end
      end
      for (int i = 0; i < 5; i++) prv[i] = cur[i];
      if (cyc > 20000) begin
        $display("FAIL watchdog: cycle %0d reached, required end before 20000", cyc);
        $fatal(1, "watchdog expired");
      end
    end
  end

  // Stimulus
  initial begin
    int b, e, l, d, k, k2, p, e2, f;
    rst_n          = 1'b0;
    bus.pll_locked = 1'b1;
    bus.soft_rst   = 1'b0;
    q_snap.push_back(R);

    // Startup from reset with stable lock, then 1000 RUN cycles
    expect_ev(2, R + 18, 2'd1);
    expect_ev(2, R + 50, 2'd2);
    expect_rst(R + 50, 1'b1);
    b = R + 50;
    e = b + 1001;
    expect_ce(b, e - 1);
    q_cnt.push_back('{cyc: b + 1000, cpu: 125, psg: 62});
    expect_rst(e, 1'b0);
    expect_ev(2, e, 2'd1);
    expect_ev(2, e + 32, 2'd2);
    expect_rst(e + 32, 1'b1);
    wait_cyc(R);
    rst_n = 1'b1;

    // One-cycle soft reset in RUN
    wait_cyc(e - 1);
    bus.soft_rst = 1'b1;
    wait_cyc(e);
    bus.soft_rst = 1'b0;

    // Loss of lock in RUN, relock
    b = e + 32;
    l = b + 100;
    d = l + 3;
    k = d + 2;
    expect_ce(b, d - 1);
    expect_rst(d, 1'b0);
    expect_ev(2, d, 2'd0);
    expect_ev(2, k + 18, 2'd1);
    expect_ev(2, k + 50, 2'd2);
    expect_rst(k + 50, 1'b1);
    wait_cyc(l);
    bus.pll_locked = 1'b0;
    wait_cyc(k);
    bus.pll_locked = 1'b1;

    // Lock glitch during filtering restarts the filter 11 cycles later
    b  = k + 50;
    l  = b + 40;
    d  = l + 3;
    k2 = d + 2;
    p  = k2 + 10;
    expect_ce(b, d - 1);
    expect_rst(d, 1'b0);
    expect_ev(2, d, 2'd0);
    expect_ev(2, k2 + 29, 2'd1);
    expect_ev(2, k2 + 61, 2'd2);
    expect_rst(k2 + 61, 1'b1);
    wait_cyc(l);
    bus.pll_locked = 1'b0;
    wait_cyc(k2);
    bus.pll_locked = 1'b1;
    wait_cyc(p);
    bus.pll_locked = 1'b0;
    wait_cyc(p + 1);
    bus.pll_locked = 1'b1;

    // rst_n pulse mid-HOLD while soft_rst held high
    b  = k2 + 61;
    e2 = b + 21;
    expect_ce(b, e2 - 1);
    expect_rst(e2, 1'b0);
    expect_ev(2, e2, 2'd1);
    expect_ev(2, e2 + 6, 2'd0);
    q_snap.push_back(e2 + 6);
    expect_ev(2, e2 + 24, 2'd1);
    expect_ev(2, e2 + 62, 2'd2);
    expect_rst(e2 + 62, 1'b1);
    f = e2 + 62 + 20;
    expect_ce(e2 + 62, f - 1);
    wait_cyc(b + 20);
    bus.soft_rst = 1'b1;
    wait_cyc(e2 + 5);
    rst_n = 1'b0;
    wait_cyc(e2 + 6);
    rst_n = 1'b1;
    wait_cyc(e2 + 30);
    bus.soft_rst = 1'b0;

    wait_cyc(f);
    done = 1'b1;
  end

endmodule
